// File: rtl/reg_dump_engine.sv
// reg_dump_engine: walks every register-file entry in index order, capturing each
// read into a registered valid/ready stream word, then pulses done once.
module reg_dump_engine #(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic [ADDR_BITS-1:0] rfAddress,
  input  logic [WIDTH-1:0]     rfReadData,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [WIDTH-1:0]     outData,
  output logic [ADDR_BITS-1:0] outIndex,
  output logic                 outLast,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    CAPTURE,
    SEND,
    DONE
  } stateT;

  localparam logic [ADDR_BITS-1:0] lastIndex = '1;
  localparam logic [ADDR_BITS-1:0] indexStep = 1;

  stateT                state;
  logic [ADDR_BITS-1:0] index;

  // The index register is the read address: it is 0 in IDLE and only moves
  // on a SEND handshake, so it is already stable through ADDR and CAPTURE.
  assign rfAddress = index;

  // Dump sequencer with registered stream, busy and done outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      index    <= '0;
      outValid <= 1'b0;
      outData  <= '0;
      outIndex <= '0;
      outLast  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= ADDR;
            index <= '0;
            busy  <= 1'b1;
          end
        end
        ADDR: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          outData  <= rfReadData;
          outIndex <= index;
          outLast  <= (index == lastIndex);
          outValid <= 1'b1;
          state    <= SEND;
        end
        SEND: begin
          if (outReady) begin
            outValid <= 1'b0;
            if (outLast) begin
              outLast <= 1'b0;
              index   <= '0;
              done    <= 1'b1;
              state   <= DONE;
            end else begin
              index <= index + indexStep;
              state <= ADDR;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_engine.sv
// Bench for reg_dump_engine: behavioural register files feed two instances
// (16x16 and 4x8); expected words are queued at stimulus time and popped as
// the stream hands them over.
module tb_reg_dump_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, outReady;
  logic [3:0]  rfAddress, outIndex;
  logic [15:0] rfReadData, outData;
  logic        outValid, outLast, busy, done;

  logic        start8;
  logic        outReady8;
  logic [1:0]  rfAddress8, outIndex8;
  logic [7:0]  rfReadData8, outData8;
  logic        outValid8, outLast8, busy8, done8;

  logic [15:0] regs  [16];
  logic [7:0]  regs8 [4];

  reg_dump_engine #(.WIDTH(16), .ADDR_BITS(4)) dut (
    .clk(clk), .reset(reset), .start(start), .rfAddress(rfAddress),
    .rfReadData(rfReadData), .outValid(outValid), .outReady(outReady),
    .outData(outData), .outIndex(outIndex), .outLast(outLast),
    .busy(busy), .done(done)
  );

  reg_dump_engine #(.WIDTH(8), .ADDR_BITS(2)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .rfAddress(rfAddress8),
    .rfReadData(rfReadData8), .outValid(outValid8), .outReady(outReady8),
    .outData(outData8), .outIndex(outIndex8), .outLast(outLast8),
    .busy(busy8), .done(done8)
  );

  // Synchronous-read register files: data valid one clk after the address.
  always @(posedge clk) begin
    rfReadData  <= regs[rfAddress];
    rfReadData8 <= regs8[rfAddress8];
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  idx;
    logic        last;
  } expT;

  typedef struct {
    logic [7:0] data;
    logic [1:0] idx;
    logic       last;
  } exp8T;

  expT  expQ[$];
  exp8T expQ8[$];
  int   doneCount = 0, doneCount8 = 0;
  logic doneDue = 1'b0, doneDue8 = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard for the 16x16 instance.
  always @(negedge clk) begin
    if (reset) begin
      doneDue = 1'b0;
    end else begin
      chk("donePulse", done, doneDue);
      if (done) doneCount++;
      doneDue = outValid && outReady && outLast;
      if (outValid) begin
        chk("busyWhileValid", busy, 1);
        if (expQ.size() == 0) begin
          chk("unexpectedWord", expQ.size(), 1);
        end else begin
          chk("outIndex", outIndex, expQ[0].idx);
          chk("outData", outData, expQ[0].data);
          chk("outLast", outLast, expQ[0].last);
          if (outReady) void'(expQ.pop_front());
        end
      end
    end
  end

  // Scoreboard for the 4x8 instance.
  always @(negedge clk) begin
    if (reset) begin
      doneDue8 = 1'b0;
    end else begin
      chk("donePulse8", done8, doneDue8);
      if (done8) doneCount8++;
      doneDue8 = outValid8 && outReady8 && outLast8;
      if (outValid8) begin
        if (expQ8.size() == 0) begin
          chk("unexpectedWord8", expQ8.size(), 1);
        end else begin
          chk("outIndex8", outIndex8, expQ8[0].idx);
          chk("outData8", outData8, expQ8[0].data);
          chk("outLast8", outLast8, expQ8[0].last);
          if (outReady8) void'(expQ8.pop_front());
        end
      end
    end
  end

  task automatic pushDump();
    for (int n = 0; n < 16; n++) begin
      expQ.push_back('{data: regs[n], idx: 4'(n), last: (n == 15)});
    end
  endtask

  // Returns #1 after the edge that samples start.
  task automatic startDump();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic waitDone(input int limit, output int n);
    n = 0;
    while (!done && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("doneSeen", done, 1);
  endtask

  task automatic waitValid(input int limit);
    int n = 0;
    while (!outValid && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("validSeen", outValid, 1);
  endtask

  task automatic acceptWord(input int stall);
    waitValid(20);
    repeat (stall) @(posedge clk);
    #1;
    chk("validBeforeAccept", outValid, 1);
    outReady = 1'b1;
    @(posedge clk);
    #1 outReady = 1'b0;
  endtask

  initial begin
    int n, d0;
    reset = 1'b1; start = 1'b0; outReady = 1'b0;
    start8 = 1'b0; outReady8 = 1'b1;
    for (int i = 0; i < 16; i++) regs[i] = 16'(i);
    for (int i = 0; i < 4; i++) regs8[i] = 8'(8'h5C + 8'(i * 8'h37));
    repeat (3) @(posedge clk);
    #1;
    chk("rstValid", outValid, 0);
    chk("rstBusy", busy, 0);
    chk("rstDone", done, 0);
    chk("rstLast", outLast, 0);
    chk("rstAddr", rfAddress, 0);
    chk("rstData", outData, 0);
    chk("rstIndex", outIndex, 0);
    reset = 1'b0;

    // Register n holds n, outReady high: 48 clks from start sample to done.
    outReady = 1'b1;
    pushDump();
    d0 = doneCount;
    startDump();
    chk("busyAfterStart", busy, 1);
    waitDone(200, n);
    chk("dumpCycles", n, 48);
    repeat (4) @(posedge clk);
    #1;
    chk("queueDrained", expQ.size(), 0);
    chk("doneCount", doneCount - d0, 1);
    chk("idleAddr", rfAddress, 0);
    chk("idleBusy", busy, 0);

    // 0xA5A0+n with a 5-clk stall on every word.
    for (int i = 0; i < 16; i++) regs[i] = 16'hA5A0 + 16'(i);
    outReady = 1'b0;
    pushDump();
    startDump();
    for (int w = 0; w < 16; w++) acceptWord(5);
    waitDone(10, n);
    repeat (4) @(posedge clk);
    #1;
    chk("stallQueueDrained", expQ.size(), 0);

    // A second start pulse while busy must be ignored.
    for (int i = 0; i < 16; i++) regs[i] = 16'h3000 + 16'(i * 7);
    outReady = 1'b1;
    pushDump();
    d0 = doneCount;
    startDump();
    n = 0;
    while (!(outValid && outIndex == 4'd7) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("reachedWord7", outIndex, 7);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    waitDone(100, n);
    repeat (10) @(posedge clk);
    #1;
    chk("busyStartQueue", expQ.size(), 0);
    chk("busyStartDone", doneCount - d0, 1);
    chk("busyStartIdle", busy, 0);

    // Reset during SEND of index 9 abandons the dump.
    outReady = 1'b0;
    pushDump();
    startDump();
    for (int w = 0; w < 9; w++) acceptWord(1);
    waitValid(20);
    chk("sendIndex9", outIndex, 9);
    d0 = doneCount;
    reset = 1'b1;
    #1;
    chk("midRstValid", outValid, 0);
    chk("midRstBusy", busy, 0);
    chk("midRstAddr", rfAddress, 0);
    expQ.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("postRstIdle", busy, 0);
    chk("postRstNoDone", doneCount - d0, 0);
    outReady = 1'b1;
    pushDump();
    startDump();
    waitDone(200, n);
    chk("postRstCycles", n, 48);

    // start held high: two back-to-back dumps.
    for (int i = 0; i < 16; i++) regs[i] = 16'hF00F ^ 16'(i << 4);
    repeat (3) @(posedge clk);
    pushDump();
    pushDump();
    d0 = doneCount;
    @(posedge clk);
    #1 start = 1'b1;
    waitDone(200, n);
    chk("firstDumpLeft", expQ.size(), 16);
    @(posedge clk);
    #1;
    waitDone(200, n);
    start = 1'b0;
    chk("backToBackCycles", n, 49);
    repeat (10) @(posedge clk);
    #1;
    chk("b2bQueue", expQ.size(), 0);
    chk("b2bDone", doneCount - d0, 2);
    chk("b2bIdle", busy, 0);

    // Narrow instance: 4 words of 8 bits.
    for (int i = 0; i < 4; i++) begin
      expQ8.push_back('{data: regs8[i], idx: 2'(i), last: (i == 3)});
    end
    @(posedge clk);
    #1 start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    n = 0;
    while (!done8 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("done8Seen", done8, 1);
    chk("dump8Cycles", n, 12);
    repeat (6) @(posedge clk);
    #1;
    chk("queue8Drained", expQ8.size(), 0);
    chk("done8Count", doneCount8, 1);
    chk("idle8", busy8, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_dump_engine.md
REG_DUMP_ENGINE -- requirements
Module: reg_dump_engine

Interface
REQ-001 Parameter WIDTH, default 16, data width of the register file read port and output stream.
REQ-002 Parameter ADDR_BITS, default 4; the block dumps 2^ADDR_BITS registers.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 start  input  1  request a full dump; sampled only in IDLE.
REQ-006 rfAddress  output  ADDR_BITS  read address driven to the register file read port 1.
REQ-007 rfReadData  input  WIDTH  register file read data, valid one clk after rfAddress is stable.
REQ-008 outValid  output  1  stream word valid.
REQ-009 outReady  input  1  downstream accepts the word when high together with outValid.
REQ-010 outData  output  WIDTH  captured register contents.
REQ-011 outIndex  output  ADDR_BITS  register index of outData.
REQ-012 outLast  output  1  high with outValid for index 2^ADDR_BITS-1.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-clk pulse after the last word is accepted.

Function
REQ-015 FSM states: IDLE, ADDR, CAPTURE, SEND, DONE; all outputs registered.
REQ-016 IDLE: start=1 -> ADDR, index counter := 0; start=0 -> stay.
REQ-017 ADDR: rfAddress = index for one clk -> CAPTURE.
REQ-018 CAPTURE: outData := rfReadData, outIndex := index, outLast := (index == 2^ADDR_BITS-1) -> SEND.
REQ-019 SEND: outValid=1; outData, outIndex and outLast held stable until outValid&&outReady.
REQ-020 SEND handshake with outLast=0: index := index+1 -> ADDR; outValid deasserts on the next clk.
REQ-021 SEND handshake with outLast=1: -> DONE; index wraps to 0.
REQ-022 DONE: done=1 for exactly one clk -> IDLE; busy falls on the same edge done falls.
REQ-023 outReady high outside SEND has no effect; no word is counted without outValid.
REQ-024 start while busy is ignored; no restart and no queued request.
REQ-025 start held continuously: a new dump begins on the clk after DONE returns to IDLE.
REQ-026 Minimum throughput: one word per 3 clks with outReady tied high; full dump of 16 words = 48 clks from start sample to done pulse, plus 1 clk for DONE.
REQ-027 rfAddress holds the current index during ADDR and CAPTURE; it holds 0 in IDLE.
REQ-028 The block never drives a write to the register file; read-only consumer.
REQ-029 Index arithmetic is ADDR_BITS wide, modulo 2^ADDR_BITS; no out-of-range address is produced.

Reset
REQ-030 reset=1 forces IDLE asynchronously; index, rfAddress, outData and outIndex reset to 0; outValid, outLast, busy and done reset to 0.
REQ-031 reset mid-dump abandons the dump; no further words and no done pulse are produced.
REQ-032 After reset deasserts, the block waits in IDLE for a new start.

Verification
REQ-033 Preload register n with value n (n=0..15); pulse start with outReady=1 -> 16 words, index/data 0x0..0xF in order, outLast only on index 15, done pulse 1 clk after word 15 is accepted.
REQ-034 Preload regs with 0xA5A0+n; hold outReady=0 for 5 clks at each word -> outValid stays high, outData stable at each value, no index skipped or duplicated.
REQ-035 Pulse start again at word 7 while busy -> dump continues to index 15, exactly one done pulse, no second dump.
REQ-036 Assert reset during SEND of index 9 -> outValid=0, busy=0 immediately; the next start dumps from index 0.
REQ-037 Hold start=1 permanently with outReady=1 -> back-to-back dumps, each 16 words, one done pulse between them, index restarts at 0.
REQ-038 WIDTH=8, ADDR_BITS=2 instance -> exactly 4 words, outLast on index 3, data is the 8-bit register contents.
